// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - 6502 operand fetch and effective-address resolution
// Optional feature: OFU_JMP_IND_BUG_EN (NMOS page-wrap on the JMP (ind) pointer high-byte read)
module operand_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic [15:0] pc,
  input  logic [7:0]  x_reg,
  input  logic [7:0]  y_reg,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] ea,
  output logic [7:0]  operand,
  output logic [15:0] pc_next,
  output logic        ea_valid,
  output logic        page_cross,
  output logic        illegal
);

  localparam logic [3:0] M_ACC  = 4'h0;
  localparam logic [3:0] M_IMM  = 4'h1;
  localparam logic [3:0] M_ZP   = 4'h2;
  localparam logic [3:0] M_ZPX  = 4'h3;
  localparam logic [3:0] M_ZPY  = 4'h4;
  localparam logic [3:0] M_ABS  = 4'h5;
  localparam logic [3:0] M_ABSX = 4'h6;
  localparam logic [3:0] M_ABSY = 4'h7;
  localparam logic [3:0] M_IND  = 4'h8;
  localparam logic [3:0] M_INDX = 4'h9;
  localparam logic [3:0] M_INDY = 4'hA;
  localparam logic [3:0] M_IMPL = 4'hB;
  localparam logic [3:0] M_REL  = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  lo_q, lo_d, plo_q, plo_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] ea_q, ea_d, pc_next_q, pc_next_d;
  logic [7:0]  operand_q, operand_d;
  logic        ea_valid_q, ea_valid_d;
  logic        page_cross_q, page_cross_d;
  logic        illegal_q, illegal_d;

  logic        rd_ok, start_no_read, start_invalid;
  logic [7:0]  idx;
  logic [15:0] abs_base, abs_ea, ptr_base, indy_ea, rel_base, rel_ea;

  assign rd_ok         = mem_rd_q && mem_ready;
  assign start_invalid = (mode > M_REL);
  assign start_no_read = (mode == M_ACC) || (mode == M_IMPL) || start_invalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = start_no_read ? S_DONE : S_OP_LO;
      S_OP_LO:  if (rd_ok) begin
        case (mode_q)
          M_ABS, M_ABSX, M_ABSY, M_IND: state_d = S_OP_HI;
          M_INDX, M_INDY:               state_d = S_PTR_LO;
          default:                      state_d = S_DONE;
        endcase
      end
      S_OP_HI:  if (rd_ok) state_d = (mode_q == M_IND) ? S_PTR_LO : S_DONE;
      S_PTR_LO: if (rd_ok) state_d = S_PTR_HI;
      S_PTR_HI: if (rd_ok) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    mode_d       = mode_q;
    pc_d         = pc_q;
    x_d          = x_q;
    y_d          = y_q;
    lo_d         = lo_q;
    plo_d        = plo_q;
    mem_addr_d   = mem_addr_q;
    ea_d         = ea_q;
    pc_next_d    = pc_next_q;
    operand_d    = operand_q;
    ea_valid_d   = ea_valid_q;
    page_cross_d = page_cross_q;
    illegal_d    = illegal_q;
    mem_rd_d     = (state_d == S_OP_LO) || (state_d == S_OP_HI) ||
                   (state_d == S_PTR_LO) || (state_d == S_PTR_HI);

    idx      = ((mode_q == M_ZPX) || (mode_q == M_ABSX)) ? x_q : y_q;
    abs_base = {mem_rdata, lo_q};
    abs_ea   = abs_base + {8'h00, idx};
    ptr_base = {mem_rdata, plo_q};
    indy_ea  = ptr_base + {8'h00, y_q};
    rel_base = pc_q + 16'd1;
    rel_ea   = rel_base + {{8{mem_rdata[7]}}, mem_rdata};

    case (state_q)
      S_IDLE: if (start) begin
        mode_d       = mode;
        pc_d         = pc;
        x_d          = x_reg;
        y_d          = y_reg;
        page_cross_d = 1'b0;
        illegal_d    = 1'b0;
        if (start_no_read) begin
          ea_d       = 16'h0000;
          ea_valid_d = 1'b0;
          pc_next_d  = pc;
          operand_d  = 8'h00;
          illegal_d  = start_invalid;
        end else begin
          mem_addr_d = pc;
        end
      end
      S_OP_LO: if (rd_ok) begin
        lo_d = mem_rdata;
        case (mode_q)
          M_ABS, M_ABSX, M_ABSY, M_IND: mem_addr_d = pc_q + 16'd1;
          M_INDX: mem_addr_d = {8'h00, mem_rdata + x_q};
          M_INDY: mem_addr_d = {8'h00, mem_rdata};
          default: begin
            operand_d  = mem_rdata;
            pc_next_d  = pc_q + 16'd1;
            ea_valid_d = 1'b1;
            case (mode_q)
              M_IMM:        ea_d = pc_q;
              M_ZPX, M_ZPY: ea_d = {8'h00, mem_rdata + idx};
              M_REL: begin
                ea_d         = rel_ea;
                page_cross_d = (rel_ea[15:8] != rel_base[15:8]);
              end
              default:      ea_d = {8'h00, mem_rdata};
            endcase
          end
        endcase
      end
      S_OP_HI: if (rd_ok) begin
        if (mode_q == M_IND) begin
          mem_addr_d = abs_base;
        end else begin
          operand_d  = lo_q;
          pc_next_d  = pc_q + 16'd2;
          ea_valid_d = 1'b1;
          if (mode_q == M_ABS) begin
            ea_d = abs_base;
          end else begin
            ea_d         = abs_ea;
            page_cross_d = (abs_ea[15:8] != mem_rdata);
          end
        end
      end
      S_PTR_LO: if (rd_ok) begin
        plo_d = mem_rdata;
        // Zero-page pointers always wrap within page 0; JMP (ind) is 16-bit unless the bug is modelled
        if (mode_q == M_IND) begin
`ifdef OFU_JMP_IND_BUG_EN
          mem_addr_d = {mem_addr_q[15:8], mem_addr_q[7:0] + 8'd1};
`else
          mem_addr_d = mem_addr_q + 16'd1;
`endif
        end else begin
          mem_addr_d = {8'h00, mem_addr_q[7:0] + 8'd1};
        end
      end
      S_PTR_HI: if (rd_ok) begin
        operand_d  = lo_q;
        ea_valid_d = 1'b1;
        pc_next_d  = (mode_q == M_IND) ? pc_q + 16'd2 : pc_q + 16'd1;
        if (mode_q == M_INDY) begin
          ea_d         = indy_ea;
          page_cross_d = (indy_ea[15:8] != mem_rdata);
        end else begin
          ea_d = ptr_base;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 4'h0;
      pc_q         <= 16'h0000;
      x_q          <= 8'h00;
      y_q          <= 8'h00;
      lo_q         <= 8'h00;
      plo_q        <= 8'h00;
      mem_addr_q   <= 16'h0000;
      mem_rd_q     <= 1'b0;
      ea_q         <= 16'h0000;
      pc_next_q    <= 16'h0000;
      operand_q    <= 8'h00;
      ea_valid_q   <= 1'b0;
      page_cross_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pc_q         <= pc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      lo_q         <= lo_d;
      plo_q        <= plo_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      ea_q         <= ea_d;
      pc_next_q    <= pc_next_d;
      operand_q    <= operand_d;
      ea_valid_q   <= ea_valid_d;
      page_cross_q <= page_cross_d;
      illegal_q    <= illegal_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign ea         = ea_q;
  assign operand    = operand_q;
  assign pc_next    = pc_next_q;
  assign ea_valid   = ea_valid_q;
  assign page_cross = page_cross_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb/tb_operand_fetch_unit.sv - directed table-driven bench for operand_fetch_unit
// Expected IND result follows OFU_JMP_IND_BUG_EN.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  mode;
  logic [15:0] pc;
  logic [7:0]  x_reg, y_reg;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy, done;
  logic [15:0] ea, pc_next;
  logic [7:0]  operand;
  logic        ea_valid, page_cross, illegal;

  logic [7:0]  mem [0:65535];

  operand_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .pc(pc),
    .x_reg(x_reg), .y_reg(y_reg), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .ea(ea), .operand(operand), .pc_next(pc_next), .ea_valid(ea_valid),
    .page_cross(page_cross), .illegal(illegal)
  );

  assign mem_rdata = mem[mem_addr];
  always #5 clk = ~clk;

`ifdef OFU_JMP_IND_BUG_EN
  localparam logic [15:0] IND_EA = 16'h5080;
`else
  localparam logic [15:0] IND_EA = 16'h4080;
`endif

  typedef struct {
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;
    logic [3:0]  mode;
    logic [15:0] pc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] e_ea;
    logic [15:0] e_pcn;
    logic [7:0]  e_op;
    logic        e_ev;
    logic        e_pcx;
    logic        e_ill;
    int          e_lat;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input logic pe, input logic [15:0] pa, input logic [7:0] pd,
                              input logic [3:0] m, input logic [15:0] p, input logic [7:0] x,
                              input logic [7:0] y, input logic [15:0] e_ea, input logic [15:0] e_pcn,
                              input logic [7:0] e_op, input logic e_ev, input logic e_pcx,
                              input logic e_ill, input int e_lat);
    vec_t v;
    v.poke_en = pe; v.poke_addr = pa; v.poke_data = pd;
    v.mode = m; v.pc = p; v.x = x; v.y = y;
    v.e_ea = e_ea; v.e_pcn = e_pcn; v.e_op = e_op;
    v.e_ev = e_ev; v.e_pcx = e_pcx; v.e_ill = e_ill; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_mem_rd"}, -1, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_busy"}, -1, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, -1, {31'd0, done}, 32'd0);
    chk({tag, "_mem_addr"}, -1, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_ea"}, -1, {16'd0, ea}, 32'd0);
    chk({tag, "_pc_next"}, -1, {16'd0, pc_next}, 32'd0);
    chk({tag, "_operand"}, -1, {24'd0, operand}, 32'd0);
    chk({tag, "_flags"}, -1, {29'd0, ea_valid, page_cross, illegal}, 32'd0);
  endtask

  task automatic issue(input logic [3:0] m, input logic [15:0] p, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    mode = m; pc = p; x_reg = x; y_reg = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 4'hB; pc = 16'hFFFF; x_reg = 8'h00; y_reg = 8'h00;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int reads;
    if (v.poke_en) mem[v.poke_addr] = v.poke_data;
    issue(v.mode, v.pc, v.x, v.y);
    cyc = 1;
    reads = 0;
    while (1) begin
      if (mem_rd && mem_ready) reads++;
      if (done || cyc >= 30) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", idx, cyc, v.e_lat);
    chk("reads", idx, reads, v.e_lat - 1);
    chk("ea", idx, {16'd0, ea}, {16'd0, v.e_ea});
    chk("pc_next", idx, {16'd0, pc_next}, {16'd0, v.e_pcn});
    chk("operand", idx, {24'd0, operand}, {24'd0, v.e_op});
    chk("ea_valid", idx, {31'd0, ea_valid}, {31'd0, v.e_ev});
    chk("page_cross", idx, {31'd0, page_cross}, {31'd0, v.e_pcx});
    chk("illegal", idx, {31'd0, illegal}, {31'd0, v.e_ill});
    @(posedge clk); #1;
    chk("idle_after", idx, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h12;
    mem[16'h0300] = 8'hF0;
    mem[16'h0310] = 8'hFF; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0320] = 8'hFF; mem[16'h0321] = 8'h30;
    mem[16'h30FF] = 8'h80; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h40;
    mem[16'h0400] = 8'hA9;
    mem[16'h0410] = 8'h42;
    mem[16'h0420] = 8'h80;
    mem[16'h0430] = 8'h34; mem[16'h0431] = 8'h12;
    mem[16'h0440] = 8'h10; mem[16'h0441] = 8'h20;
    mem[16'h0450] = 8'hF8; mem[16'h0002] = 8'hCD; mem[16'h0003] = 8'hAB;
    mem[16'h0460] = 8'hFE;
    mem[16'h0470] = 8'h04; mem[16'h0004] = 8'hF0; mem[16'h0005] = 8'h12;

    //          poke            mode   pc        x      y      ea        pc_next   op    ev    pcx   ill  lat
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h6, 16'h0200, 8'h20, 8'h00, 16'h1310, 16'h0202, 8'hF0, 1, 1, 0, 3));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h2, 16'h0410, 8'h00, 8'h00, 16'h0042, 16'h0411, 8'h42, 1, 0, 0, 2));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h3, 16'h0300, 8'h20, 8'h00, 16'h0010, 16'h0301, 8'hF0, 1, 0, 0, 2));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h4, 16'h0420, 8'h00, 8'h05, 16'h0085, 16'h0421, 8'h80, 1, 0, 0, 2));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h1, 16'h0400, 8'h00, 8'h00, 16'h0400, 16'h0401, 8'hA9, 1, 0, 0, 2));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h5, 16'h0430, 8'h00, 8'h00, 16'h1234, 16'h0432, 8'h34, 1, 0, 0, 3));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h7, 16'h0440, 8'h00, 8'h05, 16'h2015, 16'h0442, 8'h10, 1, 0, 0, 3));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h9, 16'h0450, 8'h0A, 8'h00, 16'hABCD, 16'h0451, 8'hF8, 1, 0, 0, 4));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h9, 16'h0460, 8'h01, 8'h00, 16'h1234, 16'h0461, 8'hFE, 1, 0, 0, 4));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'hA, 16'h0310, 8'h00, 8'h10, 16'h1244, 16'h0311, 8'hFF, 1, 0, 0, 4));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'hA, 16'h0470, 8'h00, 8'h20, 16'h1310, 16'h0471, 8'h04, 1, 1, 0, 4));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h8, 16'h0320, 8'h00, 8'h00, IND_EA,   16'h0322, 8'hFF, 1, 0, 0, 5));
    vq.push_back(mk(1, 16'h10FE, 8'h80, 4'hC, 16'h10FE, 8'h00, 8'h00, 16'h107F, 16'h10FF, 8'h80, 1, 0, 0, 2));
    vq.push_back(mk(1, 16'h10FE, 8'h05, 4'hC, 16'h10FE, 8'h00, 8'h00, 16'h1104, 16'h10FF, 8'h05, 1, 1, 0, 2));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'h0, 16'h0500, 8'h00, 8'h00, 16'h0000, 16'h0500, 8'h00, 0, 0, 0, 1));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'hD, 16'h0510, 8'h00, 8'h00, 16'h0000, 16'h0510, 8'h00, 0, 0, 1, 1));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'hB, 16'h0520, 8'h00, 8'h00, 16'h0000, 16'h0520, 8'h00, 0, 0, 0, 1));
    vq.push_back(mk(0, 16'h0, 8'h0, 4'hF, 16'h0530, 8'h00, 8'h00, 16'h0000, 16'h0530, 8'h00, 0, 0, 1, 1));

    rst_n = 1'b0; start = 1'b0; mode = 4'h0; pc = 16'h0; x_reg = 8'h0; y_reg = 8'h0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Stall three cycles on the OP_HI read of an ABS fetch
    issue(4'h5, 16'h0430, 8'h00, 8'h00);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", i, {16'd0, mem_addr}, 32'h0431);
      chk("stall_rd", i, {31'd0, mem_rd}, 32'd1);
      chk("stall_done", i, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    chk("stall_addr_release", 0, {16'd0, mem_addr}, 32'h0431);
    @(posedge clk); #1;
    chk("stall_done_cycle6", 0, {31'd0, done}, 32'd1);
    chk("stall_ea", 0, {16'd0, ea}, 32'h1234);
    @(posedge clk); #1;

    // Start pulses during OP_LO and DONE must be ignored
    issue(4'h2, 16'h0410, 8'h00, 8'h00);
    start = 1'b1; mode = 4'h0; pc = 16'h0500;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done", 0, {31'd0, done}, 32'd1);
    chk("ign_ea", 0, {16'd0, ea}, 32'h0042);
    chk("ign_ea_valid", 0, {31'd0, ea_valid}, 32'd1);
    start = 1'b1; mode = 4'h1; pc = 16'h0400;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy_after_done", 0, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("ign_busy_idle", 1, {31'd0, busy}, 32'd0);
    chk("ign_ea_hold", 1, {16'd0, ea}, 32'h0042);

    // Asynchronous reset in the middle of PTR_LO
    issue(4'hA, 16'h0310, 8'h00, 8'h10);
    @(posedge clk); #1;
    chk("ptr_lo_addr", 0, {16'd0, mem_addr}, 32'h00FF);
    chk("ptr_lo_rd", 0, {31'd0, mem_rd}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    c = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, vq[4]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
